// File: rtl/image_encrypter.sv
// Streams source-RAM pixels into 64-bit blocks, runs each block through an external
// DES encrypt core via an en/done/ack handshake, and writes the ciphertext bytes out.
module image_encrypter #(
    parameter int NUM_PIXELS = 30625,
    parameter int ADDR_W     = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              encrypter_active,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [7:0]        plain_data,
    output logic [ADDR_W-1:0] write_addr,
    output logic [7:0]        encrypted_data,
    output logic              write_en,
    output logic [63:0]       core_message,
    output logic              core_en,
    input  logic              core_done,
    input  logic [63:0]       core_result,
    output logic              core_ack,
    output logic              done
);

    localparam int                NUM_BLOCKS = (NUM_PIXELS + 7) / 8;
    localparam int                BLK_W      = ADDR_W - 3;
    localparam logic [BLK_W-1:0]  LAST_BLK   = BLK_W'(NUM_BLOCKS - 1);
    localparam logic [ADDR_W:0]   PIX_LIMIT  = (ADDR_W + 1)'(NUM_PIXELS);

    typedef enum logic [2:0] {
        IDLE, READ, START, WAIT, ACK, WRITE, NEXT, DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [BLK_W-1:0]  r_block;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_read_addr;
    logic [63:0]       r_msg;
    logic [63:0]       r_res;

    logic [2:0]        w_cap_idx;
    logic [ADDR_W-1:0] w_cap_addr;
    logic [7:0]        w_cap_byte;

    // Byte captured in READ cycle c belongs to the address driven in cycle c-1
    assign w_cap_idx  = r_cnt[2:0] - 3'd1;
    assign w_cap_addr = {r_block, w_cap_idx};
    assign w_cap_byte = ({1'b0, w_cap_addr} >= PIX_LIMIT) ? 8'h00 : plain_data;

    assign read_addr    = r_read_addr;
    assign core_message = r_msg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        write_en       = 1'b0;
        write_addr     = '0;
        encrypted_data = 8'h00;
        core_en        = 1'b0;
        core_ack       = 1'b0;
        done           = 1'b0;
        if (r_state != IDLE && !encrypter_active) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:  if (encrypter_active) w_next = READ;
                READ:  if (r_cnt == 4'd8) w_next = START;
                START: w_next = WAIT;
                WAIT:  if (core_done) w_next = ACK;
                ACK:   w_next = WRITE;
                WRITE: if (r_cnt == 4'd7) w_next = NEXT;
                NEXT:  w_next = (r_block == LAST_BLK) ? DONE : READ;
                DONE:  w_next = DONE;
                default: w_next = IDLE;
            endcase
        end
        case (r_state)
            START: core_en  = 1'b1;
            ACK:   core_ack = 1'b1;
            WRITE: begin
                write_en       = 1'b1;
                write_addr     = {r_block, r_cnt[2:0]};
                encrypted_data = r_res[{~r_cnt[2:0], 3'b000} +: 8];
            end
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_block     <= '0;
            r_cnt       <= '0;
            r_read_addr <= '0;
            r_msg       <= '0;
            r_res       <= '0;
        end else if (w_next == IDLE) begin
            r_block <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_block     <= '0;
                    r_cnt       <= '0;
                    r_read_addr <= '0;
                end
                READ: begin
                    // Bytes arrive in order, so shifting in leaves byte 0 in the MSB
                    if (r_cnt != 4'd0) r_msg <= {r_msg[55:0], w_cap_byte};
                    if (r_cnt < 4'd7) r_read_addr <= {r_block, r_cnt[2:0] + 3'd1};
                    r_cnt <= (r_cnt == 4'd8) ? 4'd0 : r_cnt + 4'd1;
                end
                ACK: r_res <= core_result;
                WRITE: r_cnt <= (r_cnt == 4'd7) ? 4'd0 : r_cnt + 4'd1;
                NEXT: begin
                    if (r_block != LAST_BLK) begin
                        r_block     <= r_block + BLK_W'(1);
                        r_read_addr <= {r_block + BLK_W'(1), 3'b000};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_image_encrypter.sv
// Scoreboard bench for image_encrypter with a 9-pixel image and an XOR-key core model.
module tb_image_encrypter;
    localparam int          ADDR_W     = 15;
    localparam int          NUM_PIXELS = 9;
    localparam logic [63:0] KEY = 64'hA5A5A5A5A5A5A5A5;
    localparam logic [63:0] M0  = 64'h0001020304050607;
    localparam logic [63:0] M1  = 64'h0800000000000000;
    localparam logic [63:0] R0  = 64'hA5A4A7A6A1A0A3A2;
    localparam logic [63:0] R1  = 64'hADA5A5A5A5A5A5A5;

    logic              clk;
    logic              rst;
    logic              active;
    logic [ADDR_W-1:0] read_addr;
    logic [7:0]        plain_data;
    logic [ADDR_W-1:0] write_addr;
    logic [7:0]        encrypted_data;
    logic              write_en;
    logic [63:0]       core_message;
    logic              core_en;
    logic              core_done;
    logic [63:0]       core_result;
    logic              core_ack;
    logic              done;

    image_encrypter #(.NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(rst), .encrypter_active(active),
        .read_addr(read_addr), .plain_data(plain_data),
        .write_addr(write_addr), .encrypted_data(encrypted_data), .write_en(write_en),
        .core_message(core_message), .core_en(core_en), .core_done(core_done),
        .core_result(core_result), .core_ack(core_ack), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    int n_en   = 0;
    int lat    = 3;

    logic [63:0]       msg_q[$];
    logic [ADDR_W+7:0] wr_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_tot++;
        $display("FAIL %s: event with no expectation at %0t", name, $time);
    endtask

    // Source RAM: byte[a] = a, one-cycle read latency
    logic [7:0] src [64];
    initial for (int i = 0; i < 64; i++) src[i] = 8'(i);
    always @(posedge clk) plain_data <= src[read_addr[5:0]];

    // Core model: result = message ^ KEY, done after lat cycles, held until ack
    logic        c_busy;
    int          c_cnt;
    logic [63:0] c_msg;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_done <= 1'b0; core_result <= '0; c_busy <= 1'b0; c_cnt <= 0; c_msg <= '0;
        end else if (core_ack) begin
            core_done <= 1'b0;
        end else if (core_en) begin
            if (lat == 0) begin
                core_done <= 1'b1; core_result <= core_message ^ KEY;
            end else begin
                c_busy <= 1'b1; c_cnt <= lat; c_msg <= core_message;
            end
        end else if (c_busy) begin
            if (c_cnt <= 1) begin
                c_busy <= 1'b0; core_done <= 1'b1; core_result <= c_msg ^ KEY;
            end else begin
                c_cnt <= c_cnt - 1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a message or a write
    logic prev_en = 1'b0, prev_ack = 1'b0, prev_done = 1'b0, rise_pending = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_en = 1'b0; prev_ack = 1'b0; prev_done = 1'b0; rise_pending = 1'b0;
        end else begin
            if (core_en) begin
                n_en++;
                if (msg_q.size() == 0) fail_now("core_message");
                else chk("core_message", core_message, msg_q.pop_front());
                chk("core_en_pulse", prev_en, 1'b0);
            end
            if (core_en || core_ack) chk("en_ack_excl", core_en & core_ack, 1'b0);
            if (core_ack) chk("ack_pulse", prev_ack, 1'b0);
            if (rise_pending) chk("ack_after_done", core_ack, 1'b1);
            if (write_en) begin
                if (wr_q.size() == 0) fail_now("write");
                else chk("write", {write_addr, encrypted_data}, wr_q.pop_front());
            end
            rise_pending = core_done & ~prev_done;
            prev_en = core_en; prev_ack = core_ack; prev_done = core_done;
        end
    end

    task automatic push_block(input logic [63:0] m, input logic [63:0] r, input int base, input int nwr);
        msg_q.push_back(m);
        for (int k = 0; k < nwr; k++) wr_q.push_back({ADDR_W'(base + k), r[63-8*k -: 8]});
    endtask

    task automatic push_run();
        push_block(M0, R0, 0, 8);
        push_block(M1, R1, 8, 8);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_reached", done, 1'b1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_read_addr"}, read_addr, '0);
        chk({tag, "_write_addr"}, write_addr, '0);
        chk({tag, "_enc_data"}, encrypted_data, '0);
        chk({tag, "_write_en"}, write_en, 1'b0);
        chk({tag, "_core_msg"}, core_message, '0);
        chk({tag, "_core_en"}, core_en, 1'b0);
        chk({tag, "_core_ack"}, core_ack, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    task automatic run_full(input string tag);
        n_en = 0;
        push_run();
        active = 1'b1;
        wait_done(400);
        chk({tag, "_blocks"}, n_en, 2);
        chk({tag, "_msg_q_empty"}, msg_q.size(), 0);
        chk({tag, "_wr_q_empty"}, wr_q.size(), 0);
        @(negedge clk);
        chk({tag, "_done_hold"}, done, 1'b1);
        active = 1'b0;
        @(negedge clk);
        chk({tag, "_done_clear"}, done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1;
        active = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        lat = 3;
        run_full("L3");
        lat = 0;
        run_full("L0");

        // Abort during WRITE k=3 of block 1, then restart
        lat = 3;
        push_block(M0, R0, 0, 8);
        push_block(M1, R1, 8, 4);
        active = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (write_en && write_addr == ADDR_W'(11)) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_point_reached", found, 1'b1);
        active = 1'b0;
        @(negedge clk);
        chk("abort_write_en", write_en, 1'b0);
        chk("abort_core_en", core_en, 1'b0);
        chk("abort_wr_q_empty", wr_q.size(), 0);
        chk("abort_read_addr_hold", read_addr, 15);
        n_en = 0;
        push_run();
        active = 1'b1;
        @(negedge clk);
        chk("restart_read_addr0", read_addr, 0);
        @(negedge clk);
        chk("restart_read_addr1", read_addr, 1);
        wait_done(400);
        chk("restart_blocks", n_en, 2);
        chk("restart_wr_q_empty", wr_q.size(), 0);
        active = 1'b0;
        @(negedge clk);

        // Asynchronous reset while waiting on the core
        lat = 20;
        push_block(M0, R0, 0, 0);
        active = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (core_en) begin
                found = 1'b1;
                break;
            end
        end
        chk("wait_entered", found, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_outputs_zero("async_rst");
        chk("async_rst_msg_q_empty", msg_q.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        lat = 3;
        run_full("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
